// File: rtl/ssd_scan_mux_if.sv
// Display-data bus for ssd_scan_mux: load-side inputs and registered scan outputs.
// master drives DataIn/DpIn/BlankIn/load; slave (the scanner) drives SSD/DP/AN/frame_done.
interface ssd_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] DataIn;
    logic [NUM_DIGITS-1:0]   DpIn;
    logic [NUM_DIGITS-1:0]   BlankIn;
    logic                    load;
    logic [6:0]              SSD;
    logic                    DP;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    frame_done;

    modport master (
        output DataIn, DpIn, BlankIn, load,
        input  SSD, DP, AN, frame_done
    );

    modport slave (
        input  DataIn, DpIn, BlankIn, load,
        output SSD, DP, AN, frame_done
    );
endinterface

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment scanner with pending/shadow double buffering (tear-free).
// Optional leading-zero blanking is compiled in when macro SSD_LZB_EN is defined.
module ssd_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input logic           clk,
    input logic           rst_n,
    ssd_scan_mux_if.slave bus
);
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]        div;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    last_idx;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              nibble;
    logic [6:0]              hex_seg;
    logic [6:0]              ssd_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    always_comb begin
        tick     = (div == DIV_W'(REFRESH_DIV - 1));
        last_idx = (idx == IDX_W'(NUM_DIGITS - 1));
        boundary = tick && last_idx;
    end

    // Scan counters and the two display buffers; a load on the boundary bypasses pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div          <= '0;
            idx          <= '0;
            pend_data    <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
        end else begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick)
                idx <= last_idx ? '0 : idx + IDX_W'(1);
            if (bus.load) begin
                pend_data  <= bus.DataIn;
                pend_dp    <= bus.DpIn;
                pend_blank <= bus.BlankIn;
            end
            if (boundary) begin
                shadow_data  <= bus.load ? bus.DataIn  : pend_data;
                shadow_dp    <= bus.load ? bus.DpIn    : pend_dp;
                shadow_blank <= bus.load ? bus.BlankIn : pend_blank;
            end
        end
    end

`ifdef SSD_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_mask;
    logic                  zero_run;

    // Walk down from the top digit; a digit is blanked while everything above it is zero too.
    always_comb begin
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run    = zero_run && (shadow_data[4*k +: 4] == 4'h0);
            lzb_mask[k] = zero_run;
        end
        blank_mask = shadow_blank | lzb_mask;
    end
`else
    always_comb begin
        blank_mask = shadow_blank;
    end
`endif

    always_comb begin
        nibble = shadow_data[{idx, 2'b00} +: 4];
        unique case (nibble)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b0100111;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
        an_next  = ~(NUM_DIGITS'(1) << idx);
        ssd_next = blank_mask[idx] ? 7'b1111111 : hex_seg;
        dp_next  = blank_mask[idx] ? 1'b1 : ~shadow_dp[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.AN         <= '1;
            bus.SSD        <= '1;
            bus.DP         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.AN         <= an_next;
            bus.SSD        <= ssd_next;
            bus.DP         <= dp_next;
            bus.frame_done <= boundary;
        end
    end
endmodule

// File: doc/ssd_scan_mux.md
SSD_SCAN_MUX -- requirements
Module: ssd_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed seven-segment digits, legal range 1-8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 DataIn  input  4*NUM_DIGITS  hex nibble per digit; digit k is DataIn[4k+3:4k], digit 0 rightmost.
REQ-006 DpIn  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-007 BlankIn  input  NUM_DIGITS  per-digit force-blank, active-high.
REQ-008 load  input  1  one-cycle strobe capturing DataIn/DpIn/BlankIn into the pending register.
REQ-009 SSD  output  7  segments g..a, active-low, registered.
REQ-010 DP  output  1  decimal point, active-low, registered.
REQ-011 AN  output  NUM_DIGITS  digit enables, active-low, exactly one low outside reset, registered.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-013 Divider counts 0..REFRESH_DIV-1 and wraps; tick asserted when divider == REFRESH_DIV-1.
REQ-014 Digit index advances by 1 on tick; wraps from NUM_DIGITS-1 to 0; NUM_DIGITS=1 holds index 0.
REQ-015 Frame boundary = tick while index == NUM_DIGITS-1; frame_done high in the following cycle only.
REQ-016 load copies inputs into pending in the following cycle; multiple loads within a frame keep the last one.
REQ-017 At each frame boundary shadow <= pending; if load coincides with the boundary, shadow takes the current inputs directly (bypass) and pending updates too.
REQ-018 Display sources only shadow, so a value never changes mid-frame (no tearing).
REQ-019 Each cycle AN <= ~(1 << index); SSD <= hex pattern of shadow nibble[index]; DP <= ~shadow DP[index]; latency from index change to outputs is 1 cycle.
REQ-020 Hex patterns (gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110.
REQ-021 Shadow blank bit set for the indexed digit: SSD=1111111 and DP=1; AN still asserts the slot.
REQ-022 No X values on any output in any state.

Reset
REQ-023 While rst_n=0 at a rising edge: divider=0, index=0, pending=0, shadow=0, AN all 1, SSD=1111111, DP=1, frame_done=0.
REQ-024 Reset mid-frame discards the pending load and restarts the scan at digit 0; the first edge with rst_n=1 drives AN[0]=0 and SSD=1000000.

Configuration
REQ-025 Macro SSD_LZB_EN defined: leading-zero blanking; digit k (k>0) is blanked when it and all higher digits are zero in shadow, and DP for that digit is also suppressed; digit 0 is never auto-blanked.
REQ-026 SSD_LZB_EN undefined: all digits display their value; only BlankIn blanks.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 Reset release, no load -> AN sequence 1110,1101,1011,0111 each held 4 cycles, SSD=1000000 throughout; frame_done pulses every 16 cycles.
REQ-028 load DataIn=16'h1A3F mid-frame -> display unchanged until boundary; next frame digit0..3 show F(0001110),3(0110000),A(0001000),1(1111001).
REQ-029 load coincident with boundary, DataIn=16'h0008 -> that next frame shows 8 on digit 0 (bypass path).
REQ-030 DpIn=4'b0100, BlankIn=4'b0001 -> digit 2 DP=0; digit 0 slot SSD=1111111, DP=1, AN[0]=0.
REQ-031 With SSD_LZB_EN, DataIn=16'h0050 -> digits 3,2 blanked, digit 1 shows 5, digit 0 shows 0; without macro digits 3,2 show 0.
REQ-032 rst_n low for 1 cycle during digit 2 with a pending load -> outputs off that cycle, scan restarts at digit 0 showing 0, pending value never displayed.
